// File: rtl/d2l_pkg.sv
// d2l_pkg: shared definitions for the multi-lane D2L word loopback block.
//   - serial frame constants (start/stop levels, framing overhead in bits)
//   - TX and per-lane RX state encodings
//   - even-parity helper used by both the transmitter and the lane receivers
package d2l_pkg;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   FRAME_OVH = 3;      // start + parity + stop
   localparam int   MAX_SEG_W = 256;    // widest segment the parity helper accepts

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_SEND,
      TX_WAIT
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_HUNT,
      RX_DATA,
      RX_PAR,
      RX_STOP,
      RX_DONE
   } rx_state_t;

   // Even parity: the parity bit makes the total count of ones even, which is
   // simply the XOR of the segment. Callers zero-extend to MAX_SEG_W; the
   // padding does not change the XOR.
   function automatic logic even_par(input logic [MAX_SEG_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/d2l_multilane_if.sv
// d2l_multilane_if: word-level host interface of d2l_multilane.
//   master (host side) drives : out_en, loopback, DATA_IN
//   slave  (block side) drives: BUSY, DONE, ERR, LANE_ERR, DATA_OUT
// Parameters DATA_W and LANES must match the d2l_multilane instance.
interface d2l_multilane_if #(
   parameter int DATA_W = 64,
   parameter int LANES  = 4
);
   logic              out_en;
   logic              loopback;
   logic [DATA_W-1:0] DATA_IN;
   logic              BUSY;
   logic              DONE;
   logic              ERR;
   logic [LANES-1:0]  LANE_ERR;
   logic [DATA_W-1:0] DATA_OUT;

   modport master (
      output out_en, loopback, DATA_IN,
      input  BUSY, DONE, ERR, LANE_ERR, DATA_OUT
   );

   modport slave (
      input  out_en, loopback, DATA_IN,
      output BUSY, DONE, ERR, LANE_ERR, DATA_OUT
   );
endinterface

// File: rtl/d2l_lane_rx.sv
// d2l_lane_rx: receiver for one serial lane.
//   clk, rstn : clock, asynchronous active-low reset
//   clear     : forces the receiver back to HUNT (block completion or idle)
//   line      : serial input, idle high
//   seg       : received segment, LSB first on the line
//   done      : frame fully received (stop bit sampled)
//   par_err   : received parity bit differs from the even parity of seg
//   stop_err  : stop bit sampled as 0
module d2l_lane_rx
   import d2l_pkg::*;
#(
   parameter int SEG_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clear,
   input  logic             line,
   output logic [SEG_W-1:0] seg,
   output logic             done,
   output logic             par_err,
   output logic             stop_err
);

   localparam int CW = $clog2(SEG_W + 1);

   rx_state_t       state;
   logic [CW-1:0]   cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= RX_HUNT;
         cnt      <= '0;
         seg      <= '0;
         par_err  <= 1'b0;
         stop_err <= 1'b0;
      end else if (clear) begin
         state <= RX_HUNT;
         cnt   <= '0;
      end else begin
         case (state)
            RX_HUNT: begin
               if (line == START_BIT) begin
                  state    <= RX_DATA;
                  cnt      <= '0;
                  par_err  <= 1'b0;
                  stop_err <= 1'b0;
               end
            end
            RX_DATA: begin
               // LSB arrives first, so each new bit enters at the top and
               // the first one ends up at bit 0 after SEG_W shifts.
               seg <= (seg >> 1) | (SEG_W'(line) << (SEG_W - 1));
               if (cnt == CW'(SEG_W - 1)) begin
                  state <= RX_PAR;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RX_PAR: begin
               par_err <= (line != even_par(MAX_SEG_W'(seg)));
               state   <= RX_STOP;
            end
            RX_STOP: begin
               stop_err <= (line != STOP_BIT);
               state    <= RX_DONE;
            end
            RX_DONE: begin
               // Hold until the block completes and clears every lane.
            end
            default: state <= RX_HUNT;
         endcase
      end
   end

   assign done = (state == RX_DONE);

endmodule

// File: rtl/d2l_multilane.sv
// d2l_multilane: splits a DATA_W word into LANES segments, sends each as a
// framed serial stream (start, data LSB first, even parity, stop) on its own
// lane, receives every lane independently and reassembles the word.
//   clk, rstn : clock, asynchronous active-low reset
//   host      : word-level interface (out_en, loopback, DATA_IN in;
//               BUSY, DONE, ERR, LANE_ERR, DATA_OUT out)
//   ser_in    : external receive lines, idle high (used when loopback=0)
//   ser_out   : registered transmit lines, idle high
module d2l_multilane
   import d2l_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int LANES   = 4,
   parameter int TIMEOUT = 256
) (
   input  logic              clk,
   input  logic              rstn,
   d2l_multilane_if.slave    host,
   input  logic [LANES-1:0]  ser_in,
   output logic [LANES-1:0]  ser_out
);

   localparam int SEG_W   = DATA_W / LANES;
   localparam int FRAME_W = SEG_W + FRAME_OVH;
   localparam int BCW     = $clog2(FRAME_W);
   localparam int TCW     = $clog2(TIMEOUT + 1);

   if (LANES < 1 || (DATA_W % LANES) != 0) begin : g_bad_lanes
      $error("d2l_multilane: DATA_W must be a non-zero multiple of LANES");
   end
   if (SEG_W > MAX_SEG_W) begin : g_bad_seg
      $error("d2l_multilane: segment wider than MAX_SEG_W");
   end
   if (TIMEOUT < SEG_W + 8) begin : g_bad_timeout
      $error("d2l_multilane: TIMEOUT must be at least SEG_W+8");
   end

   tx_state_t          tx_state;
   logic [BCW-1:0]     bit_cnt;
   logic [TCW-1:0]     tcnt;
   logic [FRAME_W-1:0] tx_sh [LANES];
   logic               loop_q;
   logic               busy;
   logic               done;
   logic               err;
   logic [LANES-1:0]   lane_err;
   logic [DATA_W-1:0]  data_out;

   logic [LANES-1:0]   rx_line;
   logic [DATA_W-1:0]  rx_seg;
   logic [LANES-1:0]   rx_done;
   logic [LANES-1:0]   rx_par_err;
   logic [LANES-1:0]   rx_stop_err;
   logic               rx_clear;
   logic               complete;
   logic [DATA_W-1:0]  word_next;
   logic [LANES-1:0]   lane_err_next;

   // In loopback the receivers sample the registered tx lines directly.
   assign rx_line  = loop_q ? ser_out : ser_in;

   // All-done wins over timeout in the same cycle simply because a lane that
   // is done never reports a timeout error below.
   assign complete = busy && ((&rx_done) || (tcnt == TCW'(TIMEOUT)));

   // Receivers only run while a transfer is in flight.
   assign rx_clear = complete || !busy;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      d2l_lane_rx #(.SEG_W(SEG_W)) u_rx (
         .clk      (clk),
         .rstn     (rstn),
         .clear    (rx_clear),
         .line     (rx_line[i]),
         .seg      (rx_seg[i*SEG_W +: SEG_W]),
         .done     (rx_done[i]),
         .par_err  (rx_par_err[i]),
         .stop_err (rx_stop_err[i])
      );
   end

   // NOTE: combinational blocks assign every output a default first so no
   // path leaves a value unassigned and a latch is never inferred.
   always_comb begin
      word_next     = '0;
      lane_err_next = '0;
      for (int i = 0; i < LANES; i++) begin
         // A lane that never finished contributes zero and flags an error.
         if (rx_done[i]) begin
            word_next[i*SEG_W +: SEG_W] = rx_seg[i*SEG_W +: SEG_W];
         end
         lane_err_next[i] = rx_par_err[i] | rx_stop_err[i] | ~rx_done[i];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_state <= TX_IDLE;
         bit_cnt  <= '0;
         tcnt     <= '0;
         loop_q   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         lane_err <= '0;
         data_out <= '0;
         ser_out  <= '1;
         // NOTE: the per-lane shift registers are plain flops, not a RAM, so
         // they are reset along with the rest of the state.
         for (int i = 0; i < LANES; i++) begin
            tx_sh[i] <= '1;
         end
      end else begin
         done <= 1'b0;
         if (busy) begin
            tcnt <= tcnt + TCW'(1);
         end

         case (tx_state)
            TX_IDLE: begin
               ser_out <= '1;
               if (host.out_en) begin
                  tx_state <= TX_SEND;
                  bit_cnt  <= '0;
                  tcnt     <= '0;
                  loop_q   <= host.loopback;
                  busy     <= 1'b1;
                  for (int i = 0; i < LANES; i++) begin
                     tx_sh[i] <= {STOP_BIT,
                                  even_par(MAX_SEG_W'(host.DATA_IN[i*SEG_W +: SEG_W])),
                                  host.DATA_IN[i*SEG_W +: SEG_W],
                                  START_BIT};
                  end
               end
            end
            TX_SEND: begin
               for (int i = 0; i < LANES; i++) begin
                  ser_out[i] <= tx_sh[i][0];
                  tx_sh[i]   <= {1'b1, tx_sh[i][FRAME_W-1:1]};
               end
               if (bit_cnt == BCW'(FRAME_W - 1)) begin
                  tx_state <= TX_WAIT;
               end else begin
                  bit_cnt <= bit_cnt + BCW'(1);
               end
            end
            TX_WAIT: begin
               ser_out <= '1;
            end
            default: tx_state <= TX_IDLE;
         endcase

         if (complete) begin
            tx_state <= TX_IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            ser_out  <= '1;
            data_out <= word_next;
            lane_err <= lane_err_next;
            err      <= |lane_err_next;
         end
      end
   end

   assign host.BUSY     = busy;
   assign host.DONE     = done;
   assign host.ERR      = err;
   assign host.LANE_ERR = lane_err;
   assign host.DATA_OUT = data_out;

endmodule

// File: tb/tb_d2l_multilane.sv
// tb_d2l_multilane: scoreboard bench for d2l_multilane (4 lanes) plus a
// single-lane instance. Stimulus pushes expected results computed from the
// frame rules; monitors compare whenever DONE is presented.
module tb_d2l_multilane;

   localparam int DW      = 64;
   localparam int NL      = 4;
   localparam int SW      = DW / NL;
   localparam int TIMEOUT = 256;

   typedef struct {
      logic [63:0] data;
      logic [3:0]  lerr;
      int          cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rstn;
   logic [NL-1:0] ser_in;
   logic [NL-1:0] ser_out;
   logic [0:0]    ser_in1;
   logic [0:0]    ser_out1;
   int            cyc = 0;

   int            n_cmp = 0;
   int            n_bad = 0;

   exp_t          q0[$];
   exp_t          q1[$];
   exp_t          m0;
   exp_t          m1;

   // external line model: per-lane delay, stuck-high, single data-bit flip
   int            dly[NL];
   bit            stuck[NL];
   int            flip[NL];
   int            flip_cyc[NL];
   logic [7:0]    dl[NL] = '{default: 8'hFF};

   d2l_multilane_if #(.DATA_W(DW), .LANES(NL)) bus ();
   d2l_multilane_if #(.DATA_W(DW), .LANES(1))  bus1 ();

   d2l_multilane #(.DATA_W(DW), .LANES(NL), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rstn(rstn), .host(bus), .ser_in(ser_in), .ser_out(ser_out)
   );

   d2l_multilane #(.DATA_W(DW), .LANES(1), .TIMEOUT(TIMEOUT)) dut1 (
      .clk(clk), .rstn(rstn), .host(bus1), .ser_in(ser_in1), .ser_out(ser_out1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < NL; i++) dl[i] <= {dl[i][6:0], ser_out[i]};
   end

   always_comb begin
      ser_in = '1;
      for (int i = 0; i < NL; i++) begin
         logic tap;
         tap = (dly[i] == 0) ? ser_out[i] : dl[i][(dly[i] > 0) ? dly[i] - 1 : 0];
         ser_in[i] = stuck[i] ? 1'b1 : (tap ^ (cyc == flip_cyc[i]));
      end
   end

   assign ser_in1 = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: each segment arrives intact unless a data bit is flipped
   // (odd flips -> parity error) or the lane is stuck (timeout, zero segment).
   // Latency is SEG_W+5 plus the slowest lane delay, or TIMEOUT+1 on timeout.
   function automatic exp_t model(input logic [63:0] w, input logic lb, input int e0);
      exp_t r;
      int   maxd = 0;
      bit   tmo  = 0;
      r.data = '0;
      r.lerr = '0;
      for (int i = 0; i < NL; i++) begin
         logic [SW-1:0] fm;
         fm = '0;
         if (!lb && stuck[i]) begin
            tmo = 1;
            r.lerr[i] = 1'b1;
         end else begin
            if (!lb && flip[i] >= 0) fm[flip[i]] = 1'b1;
            r.data[i*SW +: SW] = w[i*SW +: SW] ^ fm;
            r.lerr[i] = ^fm;
            if (!lb && dly[i] > maxd) maxd = dly[i];
         end
      end
      r.cyc = e0 + (tmo ? TIMEOUT + 1 : SW + 5 + maxd);
      return r;
   endfunction

   task automatic set_line(input int d0, d1, d2, d3);
      dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
      for (int i = 0; i < NL; i++) begin
         stuck[i] = 0;
         flip[i]  = -1;
      end
   endtask

   // Called at a negedge; the next posedge is the accepting edge E0.
   task automatic launch(input logic [63:0] w, input logic lb, output int e0);
      e0 = cyc + 1;
      bus.DATA_IN  = w;
      bus.loopback = lb;
      bus.out_en   = 1'b1;
      for (int i = 0; i < NL; i++)
         flip_cyc[i] = (!lb && flip[i] >= 0) ? e0 + 2 + flip[i] + dly[i] : -1;
      q0.push_back(model(w, lb, e0));
      @(negedge clk);
      bus.out_en   = 1'b0;
      bus.DATA_IN  = {$urandom, $urandom};
      bus.loopback = $urandom_range(0, 1);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || bus.BUSY || bus1.BUSY) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget)
         check("drain_pending", 64'(q0.size() + q1.size() + int'(bus.BUSY) + int'(bus1.BUSY)), 64'd0);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rstn && bus.DONE) begin
         if (q0.size() == 0) begin
            check("spurious_done", bus.DONE, 1'b0);
         end else begin
            m0 = q0.pop_front();
            check("data_out", bus.DATA_OUT, m0.data);
            check("lane_err", 64'(bus.LANE_ERR), 64'(m0.lerr));
            check("err", bus.ERR, |m0.lerr);
            check("busy_in_done", bus.BUSY, 1'b0);
            check("done_cycle", cyc, m0.cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (rstn && bus1.DONE) begin
         if (q1.size() == 0) begin
            check("spurious_done1", bus1.DONE, 1'b0);
         end else begin
            m1 = q1.pop_front();
            check("data_out1", bus1.DATA_OUT, m1.data);
            check("err1", bus1.ERR, 1'b0);
            check("done_cycle1", cyc, m1.cyc);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int n;
      logic [63:0] w;

      rstn = 1'b0;
      bus.out_en = 1'b0; bus.loopback = 1'b0; bus.DATA_IN = '0;
      bus1.out_en = 1'b0; bus1.loopback = 1'b1; bus1.DATA_IN = '0;
      set_line(0, 0, 0, 0);
      for (int i = 0; i < NL; i++) flip_cyc[i] = -1;
      repeat (3) @(negedge clk);

      check("rst_ser_out", 64'(ser_out), 64'hF);
      check("rst_busy", bus.BUSY, 1'b0);
      check("rst_done", bus.DONE, 1'b0);
      check("rst_err", bus.ERR, 1'b0);
      check("rst_lane_err", 64'(bus.LANE_ERR), 64'h0);
      check("rst_data_out", bus.DATA_OUT, 64'h0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // directed loopback
      launch(64'h9F3A_7C21_BD84_5E62, 1'b1, e0);
      check("busy_after_e0", bus.BUSY, 1'b1);
      @(negedge clk);
      check("start_bit", 64'(ser_out), 64'h0);
      drain(400);

      // external, lane 0 delayed 1, lane 2 delayed 3
      set_line(1, 0, 3, 0);
      launch(64'h14E9_A6D0_3B7C_8F51, 1'b0, e0);
      drain(400);

      // external, one data bit of lane 2 inverted
      set_line(0, 0, 0, 0);
      flip[2] = 7;
      launch(64'h0123_4567_89AB_CDEF, 1'b0, e0);
      drain(400);

      // external, lane 1 stuck high -> timeout
      set_line(0, 0, 0, 0);
      stuck[1] = 1;
      launch(64'hDEAD_BEEF_CAFE_F00D, 1'b0, e0);
      drain(400);

      // out_en at E5 ignored, out_en in the DONE cycle accepted
      set_line(0, 0, 0, 0);
      launch(64'hA5A5_3C3C_0F0F_9966, 1'b1, e0);
      while (cyc < e0 + 4) @(negedge clk);
      bus.DATA_IN = 64'h1111_2222_3333_4444;
      bus.out_en  = 1'b1;
      @(negedge clk);
      bus.out_en  = 1'b0;
      n = 0;
      while (!bus.DONE && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.DONE) check("done_wait", bus.DONE, 1'b1);
      launch(64'h7E57_0000_FFFF_8001, 1'b1, e0);
      drain(400);

      // reset at E8 mid-frame
      launch(64'h5555_AAAA_1234_8765, 1'b1, e0);
      while (cyc < e0 + 8) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("midrst_ser_out", 64'(ser_out), 64'hF);
      check("midrst_data_out", bus.DATA_OUT, 64'h0);
      check("midrst_busy", bus.BUSY, 1'b0);
      q0.delete();
      @(negedge clk);
      rstn = 1'b1;
      repeat (30) @(negedge clk);
      launch(64'hFEDC_BA98_7654_3210, 1'b1, e0);
      drain(400);

      // single-lane instance: DONE after edge E0+69
      w = 64'hC001_D00D_0BAD_F00D;
      bus1.DATA_IN = w;
      bus1.out_en  = 1'b1;
      q1.push_back('{data: w, lerr: 4'h0, cyc: cyc + 1 + 69});
      @(negedge clk);
      bus1.out_en  = 1'b0;
      bus1.DATA_IN = '0;
      drain(400);

      // randomized transfers
      for (int t = 0; t < 10; t++) begin
         logic lb;
         lb = $urandom_range(0, 1);
         set_line($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
         if ($urandom_range(0, 2) == 0) flip[$urandom_range(0, NL - 1)] = $urandom_range(0, SW - 1);
         launch({$urandom, $urandom}, lb, e0);
         drain(400);
      end

      check("q0_empty", 64'(q0.size()), 64'd0);
      check("q1_empty", 64'(q1.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
